// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: fetch port, load/store port and the memory ce/busy/valid port.
// master = arbiter view, slave = environment view (requesters plus memory).
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic        if_fault;
    logic [31:0] if_rdata;

    logic        ls_req;
    logic        ls_we;
    logic [2:0]  ls_funct3;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic        ls_fault;
    logic [31:0] ls_rdata;

    logic        mem_ce;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic        mem_memwrite;
    logic [31:0] mem_dataout;
    logic        mem_busy;
    logic        mem_valid;
    logic        mem_fault;

    modport master (
        input  if_req, if_addr,
        output if_done, if_fault, if_rdata,
        input  ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        output ls_done, ls_fault, ls_rdata,
        output mem_ce, mem_funct3, mem_addr, mem_datain, mem_memwrite,
        input  mem_dataout, mem_busy, mem_valid, mem_fault
    );

    modport slave (
        output if_req, if_addr,
        input  if_done, if_fault, if_rdata,
        output ls_req, ls_we, ls_funct3, ls_addr, ls_wdata,
        input  ls_done, ls_fault, ls_rdata,
        input  mem_ce, mem_funct3, mem_addr, mem_datain, mem_memwrite,
        output mem_dataout, mem_busy, mem_valid, mem_fault
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master memory front end: load/store has priority over fetch, one access at a time,
// ce released for at least one cycle between accesses, watchdog-bounded ISSUE phase.
module mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RELEASE} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, state_nxt;
    logic        owner_ls, owner_ls_nxt;
    logic        seen_busy, seen_busy_nxt;
    logic [15:0] watchdog, watchdog_nxt;

    logic        mem_ce_nxt;
    logic [2:0]  mem_funct3_nxt;
    logic [31:0] mem_addr_nxt;
    logic [31:0] mem_datain_nxt;
    logic        mem_memwrite_nxt;
    logic        if_done_nxt, if_fault_nxt;
    logic [31:0] if_rdata_nxt;
    logic        ls_done_nxt, ls_fault_nxt;
    logic [31:0] ls_rdata_nxt;

    // Completion terms, only meaningful while in ISSUE; fault > read > write > timeout.
    logic cmp_read, cmp_write, cmp_timeout, complete, complete_fault, take_rdata;
    assign cmp_read       = bus.mem_valid;
    assign cmp_write      = seen_busy & ~bus.mem_busy;
    assign cmp_timeout    = (watchdog == WD_LAST);
    assign complete       = bus.mem_fault | cmp_read | cmp_write | cmp_timeout;
    assign complete_fault = bus.mem_fault | (~cmp_read & ~cmp_write & cmp_timeout);
    assign take_rdata     = ~bus.mem_fault & cmp_read;

    // State and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            owner_ls         <= 1'b0;
            seen_busy        <= 1'b0;
            watchdog         <= '0;
            bus.mem_ce       <= 1'b1;
            bus.mem_funct3   <= '0;
            bus.mem_addr     <= '0;
            bus.mem_datain   <= '0;
            bus.mem_memwrite <= 1'b0;
            bus.if_done      <= 1'b0;
            bus.if_fault     <= 1'b0;
            bus.if_rdata     <= '0;
            bus.ls_done      <= 1'b0;
            bus.ls_fault     <= 1'b0;
            bus.ls_rdata     <= '0;
        end else begin
            state            <= state_nxt;
            owner_ls         <= owner_ls_nxt;
            seen_busy        <= seen_busy_nxt;
            watchdog         <= watchdog_nxt;
            bus.mem_ce       <= mem_ce_nxt;
            bus.mem_funct3   <= mem_funct3_nxt;
            bus.mem_addr     <= mem_addr_nxt;
            bus.mem_datain   <= mem_datain_nxt;
            bus.mem_memwrite <= mem_memwrite_nxt;
            bus.if_done      <= if_done_nxt;
            bus.if_fault     <= if_fault_nxt;
            bus.if_rdata     <= if_rdata_nxt;
            bus.ls_done      <= ls_done_nxt;
            bus.ls_fault     <= ls_fault_nxt;
            bus.ls_rdata     <= ls_rdata_nxt;
        end
    end

    // Next-state: IDLE -> ISSUE on any request, ISSUE -> RELEASE on completion, RELEASE -> IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.ls_req || bus.if_req) state_nxt = ISSUE;
            ISSUE:   if (complete) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of registered outputs and bookkeeping; done/fault default low for a 1-cycle pulse.
    always_comb begin
        owner_ls_nxt     = owner_ls;
        seen_busy_nxt    = seen_busy;
        watchdog_nxt     = watchdog;
        mem_ce_nxt       = bus.mem_ce;
        mem_funct3_nxt   = bus.mem_funct3;
        mem_addr_nxt     = bus.mem_addr;
        mem_datain_nxt   = bus.mem_datain;
        mem_memwrite_nxt = bus.mem_memwrite;
        if_done_nxt      = 1'b0;
        if_fault_nxt     = 1'b0;
        if_rdata_nxt     = bus.if_rdata;
        ls_done_nxt      = 1'b0;
        ls_fault_nxt     = 1'b0;
        ls_rdata_nxt     = bus.ls_rdata;
        unique case (state)
            IDLE: begin
                if (bus.ls_req) begin
                    owner_ls_nxt     = 1'b1;
                    mem_funct3_nxt   = bus.ls_funct3;
                    mem_addr_nxt     = bus.ls_addr;
                    mem_datain_nxt   = bus.ls_wdata;
                    mem_memwrite_nxt = bus.ls_we;
                    mem_ce_nxt       = 1'b0;
                    seen_busy_nxt    = 1'b0;
                    watchdog_nxt     = '0;
                end else if (bus.if_req) begin
                    owner_ls_nxt     = 1'b0;
                    mem_funct3_nxt   = 3'b010;
                    mem_addr_nxt     = bus.if_addr;
                    mem_datain_nxt   = '0;
                    mem_memwrite_nxt = 1'b0;
                    mem_ce_nxt       = 1'b0;
                    seen_busy_nxt    = 1'b0;
                    watchdog_nxt     = '0;
                end
            end
            ISSUE: begin
                seen_busy_nxt = seen_busy | bus.mem_busy;
                watchdog_nxt  = watchdog + 16'd1;
                if (complete) begin
                    mem_ce_nxt = 1'b1;
                    if (owner_ls) begin
                        ls_done_nxt  = 1'b1;
                        ls_fault_nxt = complete_fault;
                        if (take_rdata) ls_rdata_nxt = bus.mem_dataout;
                    end else begin
                        if_done_nxt  = 1'b1;
                        if_fault_nxt = complete_fault;
                        if (take_rdata) if_rdata_nxt = bus.mem_dataout;
                    end
                end
            end
            RELEASE: mem_ce_nxt = 1'b1;
            default: mem_ce_nxt = 1'b1;
        endcase
    end
endmodule
